nmos_phase_gen: RTL and testbench
=================================

Name: nmos_phase_gen

Overview:
- Two-phase non-overlapping clock sequencer for the NMOS cell library.
- Derives the PHI1 and PHI2 enables (C1, C2) from main_clk. These drive the C1/C2 inputs of every two-phase register (DFF/latch cells) in a simulated NMOS netlist.
- Provides programmable phase width and dead time, run/stop control, single-step with acknowledge, and a completed-cycle counter for the bench.

Parameters:
- DIV_W, 8, width of the phase-length and gap-length configuration inputs.
- CNT_W, 16, width of the completed-cycle counter.

Ports:
- main_clk  in  1  simulation master clock; all state changes on its rising edge.
- R_n  in  1  asynchronous active-low reset.
- en  in  1  free-run enable, level sensitive.
- step  in  1  single-cycle request pulse; honoured only in IDLE with en=0.
- ph_len  in  DIV_W  phase-high length in main_clk cycles; 0 is treated as 1.
- gap_len  in  DIV_W  dead time between phases in main_clk cycles; 0 is treated as 1.
- C1  out  1  PHI1 enable, registered.
- C2  out  1  PHI2 enable, registered.
- phi1_start  out  1  one-cycle strobe coincident with the first cycle of C1=1.
- phi2_end  out  1  one-cycle strobe coincident with the last cycle of C2=1.
- step_ack  out  1  one-cycle pulse when a single-step cycle completes.
- busy  out  1  high whenever state is not IDLE.
- cycle_cnt  out  CNT_W  number of completed PHI1+PHI2 cycles; wraps.

Behaviour:
- Reset (R_n=0, asynchronous) forces state=IDLE and cycle_cnt=0. C1, C2, phi1_start, phi2_end, step_ack and busy are all 0 immediately, without waiting for a clock edge. Release takes effect at the next main_clk edge.
- States: IDLE, PHI1, GAP1, PHI2, GAP2. A down-counter times each non-IDLE state.
- Config latching: ph_len and gap_len are sampled on entry to PHI1 and held for the whole cycle. Changes mid-cycle take effect on the next PHI1. Effective lengths are L=max(ph_len,1) and G=max(gap_len,1).
- IDLE -> PHI1:
  - occurs on the edge where en=1, or where en=0 and step=1;
  - C1=1 in the first PHI1 cycle, so start latency is 1 edge;
  - a step accepted here sets an internal step_mode flag.
- PHI1: C1=1 for L cycles, then -> GAP1.
- GAP1: C1=C2=0 for G cycles, then -> PHI2.
- PHI2: C2=1 for L cycles, then -> GAP2.
- GAP2: C1=C2=0 for G cycles. On its last cycle:
  - cycle_cnt increments (modulo 2^CNT_W);
  - if en=1 and step_mode=0, next state is PHI1 (continuous; period = 2L+2G);
  - otherwise next state is IDLE, and if step_mode=1, step_ack pulses on the edge entering IDLE and step_mode clears.
- Stop rule: en falling mid-cycle never truncates a phase. The current cycle always completes through GAP2. en is checked only on the last GAP2 cycle.
- step while busy, or while en=1, is ignored (not queued).
- step_mode=1 and en rising during the step cycle: the step cycle completes, step_ack pulses, and the block enters IDLE. It then restarts on the next edge because en=1.
- Invariants (verification asserts):
  - C1 and C2 are never both 1;
  - at least one cycle with C1=C2=0 separates every C1/C2 transition;
  - busy=0 implies C1=C2=0.
- Reset mid-operation: any state aborts to IDLE. cycle_cnt and step_mode clear, and no step_ack is produced.
- Outputs are glitch-free registered levels. Strobes are derived from next-state logic and registered alongside C1/C2.

Test Plan:
- Reset/start: hold R_n=0 with en=1 -> C1=C2=busy=0, cycle_cnt=0. Release R_n -> C1=1 and phi1_start=1 on the 1st edge.
- Continuous, ph_len=3, gap_len=1 -> C1 high 3 cycles, gap 1, C2 high 3, gap 1; period 8. cycle_cnt=1,2,3 at the end of each GAP2. C1&C2 never both 1.
- Zero config, ph_len=0, gap_len=0 -> lengths clamp to 1, period 4, non-overlap holds. Change ph_len to 2 mid-PHI2 -> the following PHI1 lasts 2 cycles; the current cycle is unchanged.
- Stop mid-cycle: en=1, then drop en during PHI2 (ph_len=3, gap_len=2) -> PHI2 and GAP2 complete fully, cycle_cnt increments once, block enters IDLE with busy=0.
- Single-step: en=0, step pulse in IDLE -> exactly one PHI1/GAP1/PHI2/GAP2 sequence, then step_ack=1 for 1 cycle and cycle_cnt+1. A second step pulse while busy -> ignored, no second cycle.
- Reset mid-PHI1, then wrap: assert R_n=0 in cycle 2 of PHI1 -> C1 drops asynchronously, cycle_cnt=0, no step_ack. With CNT_W=4, run 16 cycles -> cycle_cnt wraps 15->0.

Source files
------------

// File: rtl/nmos_phase_gen.sv
// Two-phase non-overlapping clock sequencer: derives registered PHI1/PHI2 enables (C1/C2)
// from main_clk, with programmable phase width, dead time, run/stop and single-step.
module nmos_phase_gen #(
    parameter int unsigned DIV_W = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             main_clk,
    input  logic             R_n,
    input  logic             en,
    input  logic             step,
    input  logic [DIV_W-1:0] ph_len,
    input  logic [DIV_W-1:0] gap_len,
    output logic             C1,
    output logic             C2,
    output logic             phi1_start,
    output logic             phi2_end,
    output logic             step_ack,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [2:0] {StIdle, StPhi1, StGap1, StPhi2, StGap2} state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] len_q, len_d;
    logic [DIV_W-1:0] gap_q, gap_d;
    logic             step_mode_q, step_mode_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

    logic             c1_q, c1_d;
    logic             c2_q, c2_d;
    logic             phi1_start_q, phi1_start_d;
    logic             phi2_end_q, phi2_end_d;
    logic             step_ack_q, step_ack_d;
    logic             busy_q, busy_d;

    logic [DIV_W-1:0] ph_eff, gap_eff;
    logic             cnt_last;
    logic             load;

    always_comb begin
        ph_eff   = (ph_len == '0) ? DIV_W'(1) : ph_len;
        gap_eff  = (gap_len == '0) ? DIV_W'(1) : gap_len;
        cnt_last = (cnt_q == '0);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        gap_d       = gap_q;
        step_mode_d = step_mode_q;
        cycle_cnt_d = cycle_cnt_q;
        step_ack_d  = 1'b0;
        load        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (en || step) begin
                    load        = 1'b1;
                    step_mode_d = ~en;
                end
            end
            StPhi1: begin
                if (cnt_last) begin
                    state_d = StGap1;
                    cnt_d   = gap_q - DIV_W'(1);
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            StGap1: begin
                if (cnt_last) begin
                    state_d = StPhi2;
                    cnt_d   = len_q - DIV_W'(1);
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            StPhi2: begin
                if (cnt_last) begin
                    state_d = StGap2;
                    cnt_d   = gap_q - DIV_W'(1);
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            StGap2: begin
                if (cnt_last) begin
                    cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                    // en is only consulted here, so a falling en never truncates a cycle
                    if (en && !step_mode_q) begin
                        load = 1'b1;
                    end else begin
                        state_d     = StIdle;
                        step_ack_d  = step_mode_q;
                        step_mode_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Config is captured only when a new cycle begins
        if (load) begin
            state_d = StPhi1;
            len_d   = ph_eff;
            gap_d   = gap_eff;
            cnt_d   = ph_eff - DIV_W'(1);
        end
    end

    always_comb begin
        c1_d         = (state_d == StPhi1);
        c2_d         = (state_d == StPhi2);
        phi1_start_d = (state_d == StPhi1) && (state_q != StPhi1);
        phi2_end_d   = (state_d == StPhi2) && (cnt_d == '0);
        busy_d       = (state_d != StIdle);
    end

    always_ff @(posedge main_clk or negedge R_n) begin
        if (!R_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            len_q        <= DIV_W'(1);
            gap_q        <= DIV_W'(1);
            step_mode_q  <= 1'b0;
            cycle_cnt_q  <= '0;
            c1_q         <= 1'b0;
            c2_q         <= 1'b0;
            phi1_start_q <= 1'b0;
            phi2_end_q   <= 1'b0;
            step_ack_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            gap_q        <= gap_d;
            step_mode_q  <= step_mode_d;
            cycle_cnt_q  <= cycle_cnt_d;
            c1_q         <= c1_d;
            c2_q         <= c2_d;
            phi1_start_q <= phi1_start_d;
            phi2_end_q   <= phi2_end_d;
            step_ack_q   <= step_ack_d;
            busy_q       <= busy_d;
        end
    end

    assign C1         = c1_q;
    assign C2         = c2_q;
    assign phi1_start = phi1_start_q;
    assign phi2_end   = phi2_end_q;
    assign step_ack   = step_ack_q;
    assign busy       = busy_q;
    assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_nmos_phase_gen.sv
// Self-checking bench for nmos_phase_gen: a position-in-cycle reference model predicts
// every output each main_clk cycle under directed and randomized stimulus.
module tb_nmos_phase_gen;

    localparam int DIV_W = 8;
    localparam int CNT_W = 4;

    logic             main_clk;
    logic             R_n;
    logic             en;
    logic             step;
    logic [DIV_W-1:0] ph_len;
    logic [DIV_W-1:0] gap_len;
    logic             C1, C2, phi1_start, phi2_end, step_ack, busy;
    logic [CNT_W-1:0] cycle_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: position within the current PHI1+GAP1+PHI2+GAP2 cycle
    bit m_busy;
    int m_t, m_L, m_G, m_cnt;
    bit m_sm, m_ack;

    nmos_phase_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .main_clk  (main_clk),
        .R_n       (R_n),
        .en        (en),
        .step      (step),
        .ph_len    (ph_len),
        .gap_len   (gap_len),
        .C1        (C1),
        .C2        (C2),
        .phi1_start(phi1_start),
        .phi2_end  (phi2_end),
        .step_ack  (step_ack),
        .busy      (busy),
        .cycle_cnt (cycle_cnt)
    );

    initial main_clk = 1'b0;
    always #5 main_clk = ~main_clk;

    wire [9:0] obs = {C1, C2, phi1_start, phi2_end, step_ack, busy, cycle_cnt};

    function automatic int eff(input logic [DIV_W-1:0] v);
        return (v == 0) ? 1 : int'(v);
    endfunction

    function automatic logic [9:0] exp_vec();
        logic c1e, c2e, pse, pee;
        c1e = m_busy && (m_t < m_L);
        c2e = m_busy && (m_t >= m_L + m_G) && (m_t < 2 * m_L + m_G);
        pse = m_busy && (m_t == 0);
        pee = m_busy && (m_t == 2 * m_L + m_G - 1);
        return {c1e, c2e, pse, pee, m_ack, m_busy, 4'(m_cnt)};
    endfunction

    task automatic model_reset();
        m_busy = 0; m_t = 0; m_L = 1; m_G = 1; m_cnt = 0; m_sm = 0; m_ack = 0;
    endtask

    // Advance one edge and update the model from the inputs seen at that edge
    task automatic tick();
        @(posedge main_clk);
        if (!R_n) begin
            model_reset();
        end else begin
            m_ack = 0;
            if (!m_busy) begin
                if (en || step) begin
                    m_busy = 1; m_t = 0; m_L = eff(ph_len); m_G = eff(gap_len); m_sm = !en;
                end
            end else begin
                m_t++;
                if (m_t == 2 * m_L + 2 * m_G) begin
                    m_cnt = (m_cnt + 1) % (1 << CNT_W);
                    if (en && !m_sm) begin
                        m_t = 0; m_L = eff(ph_len); m_G = eff(gap_len);
                    end else begin
                        m_busy = 0; m_ack = m_sm; m_sm = 0;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        R_n = 0; en = 1; step = 0; ph_len = 3; gap_len = 1;
        model_reset();
        repeat (3) tick();
        checks++;
        if (obs !== 10'b0) begin
            errors++; $display("FAIL reset_hold got=%b want=%b", obs, 10'b0);
        end
        R_n = 1;
        tick();
        checks++;
        if (obs !== exp_vec() || !(C1 && phi1_start)) begin
            errors++; $display("FAIL reset_release got=%b want=%b", obs, exp_vec());
        end
    endtask

    task automatic test_continuous();
        logic pc1, pc2;
        pc1 = C1; pc2 = C2;
        for (int i = 0; i < 24; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL continuous cyc=%0d got=%b want=%b", i, obs, exp_vec());
            end
            checks++;
            if ((C1 && C2) || (pc1 && C2) || (pc2 && C1)) begin
                errors++; $display("FAIL overlap cyc=%0d c1=%b c2=%b", i, C1, C2);
            end
            pc1 = C1; pc2 = C2;
        end
        checks++;
        if (cycle_cnt !== 4'd3) begin
            errors++; $display("FAIL continuous_cnt got=%0d want=3", cycle_cnt);
        end
    endtask

    task automatic test_zero_cfg();
        ph_len = 0; gap_len = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL zero_cfg cyc=%0d got=%b want=%b", i, obs, exp_vec());
            end
        end
        for (int i = 0; i < 20 && !C2; i++) tick();
        checks++;
        if (!C2) begin
            errors++; $display("FAIL zero_cfg_wait_phi2 got=%b want=1", C2);
        end
        ph_len = 2;
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL cfg_change cyc=%0d got=%b want=%b", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_stop();
        int c0;
        ph_len = 3; gap_len = 2;
        for (int i = 0; i < 40 && !C2; i++) tick();
        checks++;
        if (!C2) begin
            errors++; $display("FAIL stop_wait_phi2 got=%b want=1", C2);
        end
        en = 0;
        c0 = m_cnt;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL stop cyc=%0d got=%b want=%b", i, obs, exp_vec());
            end
        end
        checks++;
        if (busy !== 1'b0 || cycle_cnt !== 4'((c0 + 1) % 16)) begin
            errors++; $display("FAIL stop_end busy=%b cnt=%0d want busy=0 cnt=%0d",
                               busy, cycle_cnt, (c0 + 1) % 16);
        end
    endtask

    task automatic test_step();
        int c0, acks;
        ph_len = 2; gap_len = 1; en = 0; acks = 0;
        c0 = m_cnt;
        step = 1;
        for (int i = 0; i < 16; i++) begin
            tick();
            step = (i == 3);  // second pulse lands while busy
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL step cyc=%0d got=%b want=%b", i, obs, exp_vec());
            end
            if (step_ack) acks++;
        end
        checks++;
        if (acks != 1 || cycle_cnt !== 4'((c0 + 1) % 16) || busy !== 1'b0) begin
            errors++; $display("FAIL step_once acks=%0d cnt=%0d busy=%b want 1/%0d/0",
                               acks, cycle_cnt, busy, (c0 + 1) % 16);
        end
    endtask

    task automatic test_step_en_rise();
        step = 1; en = 0; ph_len = 1; gap_len = 1;
        for (int i = 0; i < 14; i++) begin
            tick();
            step = 0;
            if (i == 2) en = 1;
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL step_en_rise cyc=%0d got=%b want=%b", i, obs, exp_vec());
            end
        end
        en = 0;
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic test_reset_mid();
        en = 1; ph_len = 3; gap_len = 1;
        tick();
        tick();
        checks++;
        if (!(C1 && !phi1_start)) begin
            errors++; $display("FAIL reset_mid_pre c1=%b ps=%b want 1/0", C1, phi1_start);
        end
        #2 R_n = 0;
        model_reset();
        #1;
        checks++;
        if (obs !== 10'b0) begin
            errors++; $display("FAIL reset_mid_async got=%b want=%b", obs, 10'b0);
        end
        en = 0;
        tick();
        R_n = 1;
        tick();
        checks++;
        if (obs !== exp_vec()) begin
            errors++; $display("FAIL reset_mid_idle got=%b want=%b", obs, exp_vec());
        end
    endtask

    task automatic test_wrap();
        bit saw_wrap;
        int prev;
        saw_wrap = 0; prev = cycle_cnt;
        en = 1; ph_len = 0; gap_len = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL wrap cyc=%0d got=%b want=%b", i, obs, exp_vec());
            end
            if (prev == 15 && cycle_cnt == 0) saw_wrap = 1;
            prev = cycle_cnt;
        end
        checks++;
        if (!saw_wrap) begin
            errors++; $display("FAIL wrap_seen got=0 want=1");
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en      = ($urandom_range(0, 3) != 0);
            step    = ($urandom_range(0, 4) == 0);
            ph_len  = DIV_W'($urandom_range(0, 3));
            gap_len = DIV_W'($urandom_range(0, 3));
            if (i % 50 > 35) en = 0;
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL random cyc=%0d got=%b want=%b", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_zero_cfg();
        test_stop();
        test_step();
        test_step_en_rise();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
